// File: rtl/regfile_write_port.sv
// Write side of the integer register file: storage, one write per cycle,
// and a one-register-per-cycle bulk-clear sweep. ZERO_REG reads as constant 0.
module regfile_write_port #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wr_valid,
    output logic                                 wr_ready,
    input  logic [ADDR_WIDTH-1:0]                wr_reg,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic                                 clear_req,
    output logic                                 busy,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
    logic                  wr_fire;
    logic                  clear_active;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        wr_ready     = 1'b0;
        busy         = 1'b0;
        clear_active = 1'b0;
        case (state_q)
            IDLE: begin
                wr_ready = reset;
                if (clear_req) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
            CLEAR: begin
                busy         = 1'b1;
                clear_active = 1'b1;
                // Sweep stops before the last index, which is the hardwired zero register.
                if (clr_idx_q == ADDR_WIDTH'(NUM_REGS - 2)) begin
                    state_d   = IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                clr_idx_d = '0;
            end
        endcase
    end

    assign wr_fire = wr_valid & wr_ready;

    // Writes and sweep never coincide: writes are only accepted in IDLE.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if (gi == ZERO_REG) begin : g_zero
            assign regs_out[gi] = '0;
        end else begin : g_store
            logic [DATA_WIDTH-1:0] reg_d, reg_q;

            always_comb begin
                reg_d = reg_q;
                if (clear_active && clr_idx_q == ADDR_WIDTH'(gi)) begin
                    reg_d = '0;
                end else if (wr_fire && wr_reg == ADDR_WIDTH'(gi)) begin
                    reg_d = wr_data;
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs_out[gi] = reg_q;
        end
    end

endmodule
